// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: frame geometry,
// byte FSM state encoding and the default baud prescaler.
package uart_pkg;

    localparam int unsigned BitsPerByte      = 8;
    localparam int unsigned DefaultPrescaler = 869;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, baud counter and byte FSM. Emits a
// byte strobe on a good stop bit and a frame-error strobe on a low stop bit.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned p_baudrate_prescaler  = DefaultPrescaler,
    parameter int unsigned pw_baudrate_prescaler = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   rx,
    output logic [BitsPerByte-1:0] rx_byte,
    output logic                   byte_strobe,
    output logic                   frame_error,
    output logic                   start_edge,
    output logic                   line_idle
);

    localparam int unsigned PW = pw_baudrate_prescaler;
    localparam logic [PW-1:0] HalfCnt = PW'(p_baudrate_prescaler / 2);
    localparam logic [PW-1:0] FullCnt = PW'(p_baudrate_prescaler);
    localparam logic [2:0]    LastBit = 3'(BitsPerByte - 1);

    logic [1:0]             sync_q;
    logic                   prev_q;
    logic                   rx_s;
    uart_state_e            state_q, state_d;
    logic [PW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [BitsPerByte-1:0] shift_q, shift_d;

    assign rx_s      = sync_q[1];
    assign rx_byte   = shift_q;
    assign line_idle = (state_q == StIdle);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            prev_q    <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_strobe = 1'b0;
        frame_error = 1'b0;
        start_edge  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (prev_q && !rx_s) begin
                    start_edge = 1'b1;
                    state_d    = StStart;
                end
            end
            StStart: begin
                // Mid-bit check rejects glitches shorter than half a bit.
                if (cnt_q == HalfCnt) begin
                    cnt_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            StData: begin
                if (cnt_q == FullCnt) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[BitsPerByte-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LastBit) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            StStop: begin
                if (cnt_q == FullCnt) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_strobe = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        frame_error = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            StBreak: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/uart_rx_v1_0.sv
// UART receiver top: packs received bytes MSB-byte-first into a word of
// programmable length, discards stale partial words, and offers valid/ready.
module uart_rx_v1_0
    import uart_pkg::*;
#(
    parameter int unsigned p_baudrate_prescaler    = DefaultPrescaler,
    parameter int unsigned pw_baudrate_prescaler   = 10,
    parameter int unsigned pw_parallel_input_width = 32,
    parameter int unsigned pw_index_width          = 10,
    parameter int unsigned p_timeout_bits          = 16
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               i_rx,
    input  logic [pw_index_width-1:0]          ip_data_frame_width,
    output logic [pw_parallel_input_width-1:0] op_data,
    output logic                               o_data_valid,
    input  logic                               i_data_ready,
    output logic                               or_frame_error,
    output logic                               or_overrun
);

    localparam int unsigned W          = pw_parallel_input_width;
    localparam int unsigned PW         = pw_baudrate_prescaler;
    localparam int unsigned MaxBytes   = W / BitsPerByte;
    localparam int unsigned CountWidth = $clog2(MaxBytes + 1);
    localparam int unsigned TW         = $clog2(p_timeout_bits + 1);
    localparam logic [PW-1:0] FullCnt     = PW'(p_baudrate_prescaler);
    localparam logic [TW-1:0] TimeoutLast = TW'(p_timeout_bits - 1);

    logic [BitsPerByte-1:0] rx_byte;
    logic                   byte_strobe, frame_error, start_edge, line_idle;

    logic [W-1:0]          word_q, word_d, word_shift, data_q, data_d;
    logic [CountWidth-1:0] count_q, count_d, frame_bytes_q, frame_bytes_d, frame_bytes_req;
    logic [31:0]           width_bytes;
    logic [PW-1:0]         tick_q, tick_d;
    logic [TW-1:0]         period_q, period_d;
    logic                  valid_q, valid_d, ferr_q, ovr_q, ovr_d, timeout;
    logic                  unused_width_lsbs;

    uart_rx_byte #(
        .p_baudrate_prescaler (p_baudrate_prescaler),
        .pw_baudrate_prescaler(pw_baudrate_prescaler)
    ) u_byte (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (i_rx),
        .rx_byte    (rx_byte),
        .byte_strobe(byte_strobe),
        .frame_error(frame_error),
        .start_edge (start_edge),
        .line_idle  (line_idle)
    );

    assign unused_width_lsbs = ^ip_data_frame_width[2:0];
    assign width_bytes       = 32'(ip_data_frame_width[pw_index_width-1:3]);
    // Keeps only the low W bits, i.e. {word[W-9:0], byte}.
    assign word_shift        = W'({word_q, rx_byte});

    assign op_data        = data_q;
    assign o_data_valid   = valid_q;
    assign or_frame_error = ferr_q;
    assign or_overrun     = ovr_q;

    always_comb begin
        if (width_bytes == 32'd0) begin
            frame_bytes_req = CountWidth'(1);
        end else if (width_bytes > MaxBytes) begin
            frame_bytes_req = CountWidth'(MaxBytes);
        end else begin
            frame_bytes_req = CountWidth'(width_bytes);
        end
    end

    always_comb begin
        word_d        = word_q;
        count_d       = count_q;
        frame_bytes_d = frame_bytes_q;
        data_d        = data_q;
        valid_d       = valid_q;
        ovr_d         = 1'b0;
        tick_d        = '0;
        period_d      = '0;
        timeout       = 1'b0;

        if (line_idle && count_q != '0 && !start_edge) begin
            if (tick_q == FullCnt) begin
                if (period_q == TimeoutLast) begin
                    timeout = 1'b1;
                end else begin
                    period_d = period_q + TW'(1);
                end
            end else begin
                tick_d   = tick_q + PW'(1);
                period_d = period_q;
            end
        end

        if (start_edge && count_q == '0) begin
            frame_bytes_d = frame_bytes_req;
        end

        if (valid_q && i_data_ready) begin
            valid_d = 1'b0;
        end

        if (frame_error || timeout) begin
            word_d  = '0;
            count_d = '0;
        end else if (byte_strobe) begin
            if (count_q + CountWidth'(1) == frame_bytes_q) begin
                word_d  = '0;
                count_d = '0;
                // A held word that is being transferred this cycle frees the slot.
                if (!valid_q || i_data_ready) begin
                    data_d  = word_shift;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                word_d  = word_shift;
                count_d = count_q + CountWidth'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_q        <= '0;
            count_q       <= '0;
            frame_bytes_q <= CountWidth'(1);
            data_q        <= '0;
            valid_q       <= 1'b0;
            ferr_q        <= 1'b0;
            ovr_q         <= 1'b0;
            tick_q        <= '0;
            period_q      <= '0;
        end else begin
            word_q        <= word_d;
            count_q       <= count_d;
            frame_bytes_q <= frame_bytes_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            ferr_q        <= frame_error;
            ovr_q         <= ovr_d;
            tick_q        <= tick_d;
            period_q      <= period_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_v1_0.sv
// Scoreboard bench for uart_rx_v1_0: serial frames are driven bit by bit and
// expected words are queued, then popped as the DUT hands them over.
module tb_uart_rx_v1_0;

    localparam int unsigned P   = 15;
    localparam int unsigned BIT = P + 1;
    localparam int unsigned LAT = 2 + 1 + P / 2 + 9 * BIT + 1;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx = 1'b1;
    logic [9:0]  frame_width = 10'd8;
    logic [31:0] op_data;
    logic        valid;
    logic        ready = 1'b1;
    logic        ferr, ovr;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int xfer_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int valid_cycles = 0;
    logic valid_prev = 1'b0;
    logic [31:0] exp_q[$];

    uart_rx_v1_0 #(
        .p_baudrate_prescaler   (P),
        .pw_baudrate_prescaler  (10),
        .pw_parallel_input_width(32),
        .pw_index_width         (10),
        .p_timeout_bits         (16)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .i_rx               (rx),
        .ip_data_frame_width(frame_width),
        .op_data            (op_data),
        .o_data_valid       (valid),
        .i_data_ready       (ready),
        .or_frame_error     (ferr),
        .or_overrun         (ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each transfer and tallies flag pulses.
    always @(negedge clk) begin
        if (rstn) begin
            if (valid && !valid_prev) rise_cyc = cyc;
            if (valid) valid_cycles++;
            if (ferr) ferr_cnt++;
            if (ovr) ovr_cnt++;
            if (valid && ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("xfer_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_eq("word", op_data, exp_q.pop_front());
                end
            end
            valid_prev = valid;
        end
    end

    task automatic bit_out(input logic v);
        rx = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
        if (!stop) bit_out(1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 40 * BIT && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int x0, f0, o0;
        #1;
        check_eq("rst_data", op_data, 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_ferr", 32'(ferr), 32'd0);
        check_eq("rst_ovr", 32'(ovr), 32'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Single byte, latency and one-cycle valid
        frame_width = 10'd8;
        valid_cycles = 0;
        exp_q.push_back(32'h0000_00A5);
        send_byte(8'hA5, 1'b1);
        wait_empty("a5_drain");
        check_eq("a5_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        check_eq("a5_valid_cycles", 32'(valid_cycles), 32'd1);

        // Four-byte words
        frame_width = 10'd32;
        exp_q.push_back(32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF, 4);
        exp_q.push_back(32'hCAFE_F00D);
        send_word(32'hCAFE_F00D, 4);
        wait_empty("w32_drain");

        // Short glitch is a false start
        frame_width = 10'd8;
        x0 = xfer_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * BIT) @(posedge clk);
        #1;
        check_eq("glitch_xfers", 32'(xfer_cnt - x0), 32'd0);
        check_eq("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        exp_q.push_back(32'h0000_003C);
        send_byte(8'h3C, 1'b1);
        wait_empty("3c_drain");

        // Frame error discards the partial word
        frame_width = 10'd16;
        x0 = xfer_cnt; f0 = ferr_cnt;
        send_byte(8'h77, 1'b1);
        send_byte(8'h55, 1'b0);
        check_eq("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        check_eq("ferr_xfers", 32'(xfer_cnt - x0), 32'd0);
        exp_q.push_back(32'h0000_1234);
        send_word(32'h0000_1234, 2);
        wait_empty("ferr_next_drain");

        // Overrun while ready is low
        frame_width = 10'd16;
        ready = 1'b0;
        x0 = xfer_cnt; o0 = ovr_cnt;
        exp_q.push_back(32'h0000_A1B2);
        send_word(32'h0000_A1B2, 2);
        send_word(32'h0000_C3D4, 2);
        send_word(32'h0000_E5F6, 2);
        check_eq("ovr_pulses", 32'(ovr_cnt - o0), 32'd2);
        check_eq("ovr_held_data", op_data, 32'h0000_A1B2);
        check_eq("ovr_held_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        wait_empty("ovr_drain");
        repeat (2 * BIT) @(posedge clk);
        #1;
        check_eq("ovr_xfers", 32'(xfer_cnt - x0), 32'd1);

        // Inter-byte timeout drops a stale partial word
        frame_width = 10'd32;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        repeat (20 * BIT) @(posedge clk);
        #1;
        exp_q.push_back(32'h0102_0304);
        send_word(32'h0102_0304, 4);
        wait_empty("timeout_drain");

        // Asynchronous reset in the middle of a data bit
        frame_width = 10'd8;
        ready = 1'b0;
        send_byte(8'h99, 1'b1);
        check_eq("pre_rst_data", op_data, 32'h0000_0099);
        check_eq("pre_rst_valid", 32'(valid), 32'd1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_data", op_data, 32'd0);
        check_eq("mid_rst_valid", 32'(valid), 32'd0);
        check_eq("mid_rst_ferr", 32'(ferr), 32'd0);
        check_eq("mid_rst_ovr", 32'(ovr), 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_q.push_back(32'h0000_005A);
        send_byte(8'h5A, 1'b1);
        wait_empty("post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_v1_0.md
# uart_rx_v1_0

Serial UART receiver, the receive-side counterpart of the team's UART transmitter. Over-samples the asynchronous `i_rx` line, recovers 8N1 bytes (LSB first), and packs consecutive bytes MSB-byte-first into one parallel word of programmable width. The word is presented on a valid/ready handshake to downstream logic. A byte stream produced by the transmitter for a given word is reassembled into the identical word.

## Interface
- `p_baudrate_prescaler`, 869: bit period is `p_baudrate_prescaler+1` clk cycles.
- `pw_baudrate_prescaler`, 10: width of the baud counter; must hold `p_baudrate_prescaler`.
- `pw_parallel_input_width`, 32: output word width in bits, a multiple of 8.
- `pw_index_width`, 10: width of the frame-width input.
- `p_timeout_bits`, 16: idle bit periods after which a partially received word is discarded.

Ports:
- `clk` input 1: the single clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `i_rx` input 1: serial line, asynchronous to `clk`, idle high.
- `ip_data_frame_width` input `pw_index_width`: word length in bits.
- `op_data` output `pw_parallel_input_width`: received word, right-aligned.
- `o_data_valid` output 1: `op_data` holds a complete word.
- `i_data_ready` input 1: downstream accepts the word.
- `or_frame_error` output 1: one-cycle pulse when a stop bit is sampled low.
- `or_overrun` output 1: one-cycle pulse when a completed word is dropped.

## Operation
- Input synchronizer: 2 flops on `i_rx`, both reset to 1. All logic uses the synchronized value.
- Edge detect: a falling edge of the synchronized line in IDLE starts a byte.
- FSM states:
  - IDLE: baud counter held at 0. On a falling edge, go to START.
  - START: sample when counter = `p_baudrate_prescaler/2` (integer division).
    - Sampled low: clear counter, go to DATA.
    - Sampled high: false start, return to IDLE with no flags.
  - DATA: sample when counter = `p_baudrate_prescaler`, then wrap the counter to 0. Shift bits in LSB first; after 8 samples go to STOP.
  - STOP: sample at the full period.
    - Sampled high: append the byte and return to IDLE.
    - Sampled low: pulse `or_frame_error`, discard the partial word, go to BREAK.
  - BREAK: wait for the synchronized line high, then go to IDLE.
- Byte count per word:
  - N = `ip_data_frame_width[pw_index_width-1:3]`, latched when the first byte of a word starts.
  - N = 0 is treated as 1. N is clamped to `pw_parallel_input_width/8`.
- Assembly:
  - Each accepted byte does `word <= {word[W-9:0], byte}`, so the first byte lands in the most significant occupied byte.
  - When the N-th byte is accepted, `op_data` gets `word` zero-extended and the byte count clears.
- Inter-byte timeout:
  - While 0 < count < N in IDLE, a bit-period counter runs.
  - At `p_timeout_bits` periods without a start edge, the partial word and count clear silently.
- Output handshake:
  - `o_data_valid` rises with the load. `op_data` is stable while valid is high.
  - A transfer occurs on a cycle where both `o_data_valid` and `i_data_ready` are high; valid drops next cycle unless a new word loads that same cycle.
- Overrun: a word completes while `o_data_valid=1` and `i_data_ready=0`.
  - The new word is dropped and `or_overrun` pulses.
  - The held `op_data` is unchanged.
- Simultaneous completion and `i_data_ready=1`: the old word transfers, the new word loads, and valid stays high.

## Timing
- Reset values: `op_data=0`, `o_data_valid=0`, `or_frame_error=0`, `or_overrun=0`, FSM in IDLE, all counters 0.
- Start-bit sample: `2 + 1 + p_baudrate_prescaler/2` cycles after the `i_rx` falling edge (2 synchronizer cycles plus 1 edge-detect cycle).
- Each later sample is `p_baudrate_prescaler+1` cycles after the previous one.
- `o_data_valid` and flag pulses assert the cycle after the stop-bit sample of the relevant byte.
- Reset mid-frame: everything returns to reset values immediately. The next start edge is recognised only after the synchronized line has been seen high.

## Structure
- Shared package `uart_pkg`: state encoding (IDLE, START, DATA, STOP, BREAK), bits per byte (8), and the default prescaler. The transmitter uses the same package.
- One natural sub-module: `uart_rx_byte`, the synchronizer, baud counter and byte FSM. It outputs a byte, a byte strobe and a frame-error strobe.
- The top level holds the word packer, the timeout counter and the handshake.

## Test plan
Benches use `p_baudrate_prescaler=15`.
- Single byte 0xA5, width 8, ready high: `op_data=0x000000A5` and valid for 1 cycle, asserted the cycle after the stop-bit sample (edge-relative latency as in Timing).
- Four bytes 0xDE 0xAD 0xBE 0xEF, width 32: `op_data=0xDEADBEEF`. Loopback from the transmitter sending 0xDEADBEEF gives the same word.
- 4-cycle low glitch on `i_rx`: false start, no valid and no flags. A byte 0x3C sent afterwards is received correctly.
- Byte 0x55 with stop bit forced low: `or_frame_error` pulses once, no valid. A following 0x12 is received as a fresh word.
- Width 16, ready held low, three words sent:
  - The first word is held.
  - The second and third each produce an `or_overrun` pulse.
  - After raising ready, exactly one transfer of the first word occurs.
- Width 32, two bytes sent, then 16 bit periods idle, then 0x01 0x02 0x03 0x04: `op_data=0x01020304`.
- Assert `rstn` low mid-DATA: all outputs are 0 immediately and the next byte is received correctly.
